// File: rtl/spw_pkg.sv
// spw_pkg: SpaceWire transmit character constants and character builders
package spw_pkg;
    // control codes stored as {c1,c0}; c0 is the first code bit on the line
    localparam logic [1:0] C_FCT = 2'b00;
    localparam logic [1:0] C_EOP = 2'b10;
    localparam logic [1:0] C_EEP = 2'b01;
    localparam logic [1:0] C_ESC = 2'b11;
    localparam int LEN_CTRL = 4;
    localparam int LEN_NULL = 8;
    localparam int LEN_DATA = 10;
    localparam int LEN_TIME = 14;
    localparam int MAX_CREDIT = 56;
    localparam int CREDIT_STEP = 8;
    localparam int FCT_PEND_MAX = 7;
    typedef enum logic {IDLE, SHIFT} tx_state_e;
    typedef enum logic [2:0] {SEL_NONE, SEL_TIME, SEL_FCT, SEL_NCHAR, SEL_NULL} tx_sel_e;
    // bit0 is sent first; hist is the parity of the previous character's payload
    function automatic logic [3:0] ctrl_char(input logic hist, input logic [1:0] code);
        return {code, 1'b1, hist};
    endfunction
    function automatic logic [9:0] data_char(input logic hist, input logic [7:0] d);
        return {d, 1'b0, ~hist};
    endfunction
endpackage

// File: rtl/spw_tx_bitclk.sv
// spw_tx_bitclk: bit-period divider, one-cycle bit_tick every TX_DIV+1 cycles
module spw_tx_bitclk #(
    parameter int TX_DIV = 9
) (
    input  logic pclk,
    input  logic resetn,
    input  logic enable_tx,
    output logic bit_tick
);
    localparam int W = (TX_DIV < 1) ? 1 : $clog2(TX_DIV + 1);
    logic [W-1:0] div_q;
    assign bit_tick = resetn && enable_tx && (div_q == W'(TX_DIV));
    // free-running period counter, held at zero while the transmitter is off
    always_ff @(posedge pclk) begin
        if (!resetn || !enable_tx) div_q <= '0;
        else div_q <= bit_tick ? '0 : div_q + W'(1);
    end
endmodule

// File: rtl/spw_tx_encoder.sv
// spw_tx_encoder: SpaceWire character selection, parity and DS serialisation
module spw_tx_encoder
    import spw_pkg::*;
#(
    parameter int TX_DIV = 9,
    parameter int MAX_CREDIT = spw_pkg::MAX_CREDIT
) (
    input  logic       pclk,
    input  logic       resetn,
    input  logic       enable_tx,
    input  logic       send_null_tx,
    input  logic       send_fct_tx,
    input  logic       rx_got_fct,
    input  logic       fct_req,
    input  logic       tick_in,
    input  logic [7:0] time_in,
    input  logic       tx_valid,
    input  logic [8:0] tx_data,
    output logic       tx_ready,
    output logic       tx_credit_error,
    output logic [5:0] credit,
    output logic       dout,
    output logic       sout
);
    logic        bit_tick, clr, shift_on, nbit, credit_ovf;
    tx_state_e   state_q;
    tx_sel_e     sel;
    logic [13:0] sh_q, ld_vec;
    logic [3:0]  rem_q, ld_len;
    logic        dout_q, sout_q, hist_q, ld_hist, err_q, tpend_q, tpend_d;
    logic [5:0]  credit_q, credit_d;
    logic [6:0]  credit_add;
    logic [2:0]  fpend_q, fpend_d;
    logic [7:0]  time_q, time_d;

    spw_tx_bitclk #(.TX_DIV(TX_DIV)) u_bitclk (
        .pclk(pclk), .resetn(resetn), .enable_tx(enable_tx), .bit_tick(bit_tick)
    );

    assign clr = !resetn || !enable_tx;
    assign shift_on = (state_q == SHIFT) && (rem_q != 4'd0);
    assign sel = (!bit_tick || shift_on) ? SEL_NONE :
                 (tpend_q && send_fct_tx) ? SEL_TIME :
                 (fpend_q != 3'd0 && send_fct_tx) ? SEL_FCT :
                 (tx_valid && credit_q != 6'd0 && send_fct_tx) ? SEL_NCHAR :
                 send_null_tx ? SEL_NULL : SEL_NONE;
    assign tx_ready = (sel == SEL_NCHAR);
    assign nbit = shift_on ? sh_q[0] : ld_vec[0];

    // character image, length and resulting parity history for the selected char
    always_comb begin
        ld_vec = '0;
        ld_len = 4'd0;
        ld_hist = hist_q;
        case (sel)
            SEL_TIME: begin
                ld_vec = {data_char(1'b0, time_q), ctrl_char(hist_q, C_ESC)};
                ld_len = 4'(LEN_TIME);
                ld_hist = ^time_q;
            end
            SEL_FCT: begin
                ld_vec = {10'd0, ctrl_char(hist_q, C_FCT)};
                ld_len = 4'(LEN_CTRL);
                ld_hist = 1'b0;
            end
            SEL_NCHAR: begin
                ld_vec = tx_data[8] ? {10'd0, ctrl_char(hist_q, tx_data[0] ? C_EEP : C_EOP)}
                                    : {4'd0, data_char(hist_q, tx_data[7:0])};
                ld_len = tx_data[8] ? 4'(LEN_CTRL) : 4'(LEN_DATA);
                ld_hist = tx_data[8] ? 1'b1 : ^tx_data[7:0];
            end
            SEL_NULL: begin
                ld_vec = {6'd0, ctrl_char(1'b0, C_FCT), ctrl_char(hist_q, C_ESC)};
                ld_len = 4'(LEN_NULL);
                ld_hist = 1'b0;
            end
            default: ;
        endcase
    end

    // credit arithmetic: +8 unless it would overflow, -1 per N-char loaded
    assign credit_add = {1'b0, credit_q} + 7'(CREDIT_STEP);
    assign credit_ovf = rx_got_fct && (credit_add > 7'(MAX_CREDIT));
    assign credit_d = credit_q + ((rx_got_fct && !credit_ovf) ? 6'(CREDIT_STEP) : 6'd0)
                      - (tx_ready ? 6'd1 : 6'd0);
    assign fpend_d = (fct_req && sel != SEL_FCT && fpend_q != 3'(FCT_PEND_MAX)) ? fpend_q + 3'd1 :
                     (!fct_req && sel == SEL_FCT) ? fpend_q - 3'd1 : fpend_q;
    assign tpend_d = tick_in || (tpend_q && sel != SEL_TIME);
    assign time_d = tick_in ? time_in : time_q;

    // serialiser: load a new character or shift the current one on each bit tick
    always_ff @(posedge pclk) begin
        if (clr) begin
            state_q <= IDLE;
            sh_q <= '0;
            rem_q <= '0;
            dout_q <= 1'b0;
            sout_q <= 1'b0;
            hist_q <= 1'b0;
        end else if (bit_tick && (shift_on || sel != SEL_NONE)) begin
            state_q <= SHIFT;
            dout_q <= nbit;
            sout_q <= sout_q ^ (nbit == dout_q);
            sh_q <= shift_on ? sh_q >> 1 : ld_vec >> 1;
            rem_q <= shift_on ? rem_q - 4'd1 : ld_len - 4'd1;
            hist_q <= ld_hist;
        end else if (bit_tick) begin
            state_q <= IDLE;
        end
    end

    // credit, FCT and time-code bookkeeping
    always_ff @(posedge pclk) begin
        if (clr) begin
            credit_q <= '0;
            err_q <= 1'b0;
            fpend_q <= '0;
            tpend_q <= 1'b0;
            time_q <= '0;
        end else begin
            credit_q <= credit_d;
            err_q <= credit_ovf;
            fpend_q <= fpend_d;
            tpend_q <= tpend_d;
            time_q <= time_d;
        end
    end

    assign dout = dout_q;
    assign sout = sout_q;
    assign credit = credit_q;
    assign tx_credit_error = err_q;
endmodule
